weight_fetch_unit: RTL and testbench

- Read-side sequencer for the 180 kB weight SRAM (five 16384-word × 18 b banks, 81920 words total).
- Given a base word address and a length, it issues single-cycle reads and absorbs the SRAM's 1-cycle read latency.
- Read data is buffered in a small FIFO and presented to the PE-array weight loader over a valid/ready stream.
- It sits directly upstream of the PE array and is the only reader of the weight SRAM port during compute.

---
 rtl/weight_fetch_pkg.sv | 14 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/weight_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_weight_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/weight_fetch_pkg.sv
// rtl/weight_fetch_pkg.sv - shared constants and state type for the weight fetch unit
package weight_fetch_pkg;

  localparam int WEIGHT_WORDS = 81920;
  localparam int BANK_WORDS   = 16384;
  localparam int WEIGHT_AW    = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with synchronous flush and occupancy count
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_pop && !i_clr));

endmodule

// File: rtl/weight_fetch_unit.sv
// rtl/weight_fetch_unit.sv - weight SRAM read sequencer feeding the PE-array loader stream
module weight_fetch_unit
  import weight_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WEIGHT_AW,
  parameter int WORDS = WEIGHT_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_cs,
  output logic          mem_oe,
  output logic          mem_W_req,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_W_data,
  input  logic [31:0]   mem_R_data,
  output logic          w_valid,
  input  logic          w_ready,
  output logic [17:0]   w_data
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW:0]   r_remaining;
  logic [AW:0]   w_remaining_nxt;
  logic          r_inflight;
  logic          r_done;
  logic          r_err;
  logic          w_done_nxt;
  logic          w_err_nxt;

  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit_used;
  logic [AW+1:0] w_end_addr;
  logic          w_unused_rdata;

  assign w_end_addr    = {2'b00, base_addr} + {1'b0, len};
  assign w_credit_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

  // Slots already holding data plus the read in flight must leave room for the next word.
  assign w_issue = (r_state == FETCH) && (w_credit_used < (CW + 1)'(DEPTH));

  assign w_push  = r_inflight;
  assign w_pop   = !w_empty && w_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (18)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (abort),
    .i_push    (w_push),
    .i_wr_data (mem_R_data[17:0]),
    .i_pop     (w_pop),
    .o_rd_data (w_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_unused_rdata = ^{mem_R_data[31:18], w_full};

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              w_done_nxt = 1'b1;
            end else if (w_end_addr > (AW + 2)'(WORDS)) begin
              w_err_nxt = 1'b1;
            end else begin
              w_rd_ptr_nxt    = base_addr;
              w_remaining_nxt = len;
              w_state_nxt     = FETCH;
            end
          end
        end
        FETCH: begin
          if (w_issue) begin
            w_rd_ptr_nxt    = r_rd_ptr + 1'b1;
            w_remaining_nxt = r_remaining - 1'b1;
            if (r_remaining == (AW + 1)'(1)) w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          // Last word leaves when nothing is in flight and it is the only one buffered.
          if (!r_inflight && (w_count == CW'(1)) && w_pop) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      // Dropping the flag on abort discards the word returning next cycle.
      r_inflight  <= w_issue && !abort;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign mem_cs     = w_issue;
  assign mem_oe     = busy || r_inflight;
  assign mem_W_req  = 1'b1;
  assign mem_addr   = w_issue ? {{(32 - AW){1'b0}}, r_rd_ptr} : 32'd0;
  assign mem_W_data = 32'd0;
  assign w_valid    = !w_empty;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// tb/tb_weight_fetch_unit.sv - directed table-driven bench for weight_fetch_unit
module tb_weight_fetch_unit;
  import weight_fetch_pkg::*;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          w_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, err, mem_cs, mem_oe, mem_W_req, w_valid;
  logic [31:0]   mem_addr, mem_W_data, mem_R_data;
  logic [17:0]   w_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  weight_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_cs     (mem_cs),
    .mem_oe     (mem_oe),
    .mem_W_req  (mem_W_req),
    .mem_addr   (mem_addr),
    .mem_W_data (mem_W_data),
    .mem_R_data (mem_R_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data)
  );

  // SRAM model: word k holds k+100, one-cycle read latency, junk when not selected.
  logic [17:0] sram_word;
  assign sram_word = 18'(mem_addr + 32'd100);
  always @(posedge clk)
    mem_R_data <= mem_cs ? {{14{sram_word[17]}}, sram_word} : 32'h0003_dead;

  int          cs_n, done_n, err_n, done_cyc, err_cyc, busy_n, oe_n, addr_bad;
  logic [31:0] next_addr;
  logic [17:0] q_word[$];
  int          q_cyc[$];
  bit          snap_cs[64];
  bit          snap_busy[64];
  bit          snap_valid[64];
  bit          snap_done[64];

  typedef struct {
    int base;
    int len;
    int exp_first;
    int exp_words;
    int exp_done;
    int exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input logic [AW-1:0] b, input logic [AW:0] l, input int ncyc,
                         input int abort_at, input int rlo, input int rhi);
    cs_n = 0; done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1;
    busy_n = 0; oe_n = 0; addr_bad = 0; next_addr = 32'(b);
    q_word.delete(); q_cyc.delete();
    for (int i = 0; i < 64; i++) begin
      snap_cs[i] = 0; snap_busy[i] = 0; snap_valid[i] = 0; snap_done[i] = 0;
    end
    @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      start     = (k == 0);
      base_addr = b;
      len       = l;
      abort     = (k == abort_at);
      w_ready   = !(k >= rlo && k <= rhi);
      #1;
      if (k < 64) begin
        snap_cs[k] = mem_cs; snap_busy[k] = busy; snap_valid[k] = w_valid; snap_done[k] = done;
      end
      if (mem_cs) begin
        cs_n++;
        if (mem_addr != next_addr) addr_bad++;
        next_addr = next_addr + 1;
      end
      if (w_valid && w_ready) begin
        q_word.push_back(w_data);
        q_cyc.push_back(k);
      end
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = k; end
      if (err)  begin err_n++;  if (err_cyc < 0)  err_cyc = k;  end
      if (busy)   busy_n++;
      if (mem_oe) oe_n++;
    end
    start = 0;
    abort = 0;
    w_ready = 1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cs"}, mem_cs, 0);
    chk({tag, "_oe"}, mem_oe, 0);
    chk({tag, "_wreq"}, mem_W_req, 1);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, w_valid, 0);
    chk({tag, "_done_err"}, {done, err}, 0);
  endtask

  initial begin
    vecs[0] = '{0,     4, 100,   4, 7,  -1};
    vecs[1] = '{16382, 4, 16482, 4, 7,  -1};
    vecs[2] = '{5,     0, 0,     0, 1,  -1};
    vecs[3] = '{81918, 3, 0,     0, -1, 1};
    vecs[4] = '{81917, 3, 82017, 3, 6,  -1};
    vecs[5] = '{81919, 1, 82019, 1, 4,  -1};
    vecs[6] = '{81920, 1, 0,     0, -1, 1};
    vecs[7] = '{100,   7, 200,   7, 10, -1};

    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_wdata", mem_W_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_job(AW'(vecs[v].base), (AW + 1)'(vecs[v].len), 40, -1, 99, 98);
      chk($sformatf("v%0d_cs", v), cs_n, vecs[v].exp_words);
      chk($sformatf("v%0d_addr_bad", v), addr_bad, 0);
      chk($sformatf("v%0d_done_cyc", v), done_cyc, vecs[v].exp_done);
      chk($sformatf("v%0d_done_n", v), done_n, (vecs[v].exp_done >= 0) ? 1 : 0);
      chk($sformatf("v%0d_err_cyc", v), err_cyc, vecs[v].exp_err);
      chk($sformatf("v%0d_words", v), q_word.size(), vecs[v].exp_words);
      chk($sformatf("v%0d_busy_n", v), busy_n,
          (vecs[v].exp_words > 0) ? vecs[v].exp_done - 1 : 0);
      chk($sformatf("v%0d_oe_n", v), oe_n,
          (vecs[v].exp_words > 0) ? vecs[v].exp_done - 1 : 0);
      for (int i = 0; i < q_word.size() && i < vecs[v].exp_words; i++) begin
        chk($sformatf("v%0d_w%0d_data", v, i), q_word[i], 18'(vecs[v].exp_first + i));
        chk($sformatf("v%0d_w%0d_cyc", v, i), q_cyc[i], 3 + i);
      end
    end

    // Backpressure: consumer stalls for cycles 4..11.
    begin
      int cs_stall, cs_early, valid_stall;
      run_job(AW'(500), (AW + 1)'(10), 40, -1, 4, 11);
      cs_stall = 0; cs_early = 0; valid_stall = 0;
      for (int k = 6; k <= 11; k++) cs_stall += int'(snap_cs[k]);
      for (int k = 0; k < 6; k++) cs_early += int'(snap_cs[k]);
      for (int k = 4; k <= 11; k++) valid_stall += int'(snap_valid[k]);
      chk("bp_cs_stalled", cs_stall, 0);
      chk("bp_cs_early", cs_early, 5);
      chk("bp_valid_held", valid_stall, 8);
      chk("bp_cs_total", cs_n, 10);
      chk("bp_addr_bad", addr_bad, 0);
      chk("bp_words", q_word.size(), 10);
      chk("bp_done_n", done_n, 1);
      for (int i = 0; i < q_word.size() && i < 10; i++)
        chk($sformatf("bp_w%0d", i), q_word[i], 18'(600 + i));
    end

    // Abort at cycle 5 of a 20-word job, then restart at cycle 8.
    run_job(AW'(1000), (AW + 1)'(20), 8, 5, 99, 98);
    chk("ab_busy6", snap_busy[6], 0);
    chk("ab_valid6", snap_valid[6], 0);
    chk("ab_valid7", snap_valid[7], 0);
    chk("ab_cs67", {snap_cs[6], snap_cs[7]}, 0);
    chk("ab_done_n", done_n, 0);
    chk("ab_words", q_word.size(), 3);
    if (q_word.size() == 3) chk("ab_w2", q_word[2], 18'(1102));
    run_job(AW'(40), (AW + 1)'(2), 12, -1, 99, 98);
    chk("ab_restart_words", q_word.size(), 2);
    if (q_word.size() == 2) begin
      chk("ab_restart_w0", q_word[0], 18'(140));
      chk("ab_restart_w1", q_word[1], 18'(141));
      chk("ab_restart_cyc0", q_cyc[0], 3);
    end
    chk("ab_restart_done", done_cyc, 5);

    // Asynchronous reset during FETCH.
    run_job(AW'(2000), (AW + 1)'(20), 4, -1, 99, 98);
    @(negedge clk);
    #1;
    chk("rst_pre_cs", mem_cs, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_after_valid", w_valid, 0);
    run_job(AW'(7), (AW + 1)'(3), 12, -1, 99, 98);
    chk("rst_job_words", q_word.size(), 3);
    for (int i = 0; i < q_word.size() && i < 3; i++)
      chk($sformatf("rst_job_w%0d", i), q_word[i], 18'(107 + i));
    chk("rst_job_done", done_cyc, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
